// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues reads to a 1-cycle-latency ROM
// and buffers returned words with their PCs in a small prefetch FIFO for decode.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h0040_0000,
  parameter int                    DEPTH      = 4,
  parameter int                    PC_STEP    = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         fetch_en,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         rom_req,
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic [INST_WIDTH-1:0]        rom_data,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [INST_WIDTH-1:0]        inst_data,
  output logic [ADDR_WIDTH-1:0]        inst_pc,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = $clog2(DEPTH+1);
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetchPc_q, fetchPc_d;
  logic [ADDR_WIDTH-1:0] issuedPc_q, issuedPc_d;
  logic                  inflight_q, inflight_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [INST_WIDTH-1:0] memData_q [DEPTH];
  logic [ADDR_WIDTH-1:0] memPc_q   [DEPTH];

  logic                  pop;
  logic                  push;
  logic [CNT_W:0]        pending;

  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? memData_q[rdPtr_q] : '0;
  assign inst_pc    = inst_valid ? memPc_q[rdPtr_q]   : '0;
  assign occupancy  = count_q;
  assign rom_addr   = fetchPc_q;

  // A request may only issue if its response is guaranteed a free slot, counting
  // the in-flight word and any pop happening this cycle; a redirect kills responses.
  always_comb begin
    pop     = inst_valid & inst_ready;
    push    = inflight_q & ~redirect_valid;
    pending = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    rom_req = fetch_en & ~redirect_valid & ~reset & (pending < DEPTH_C);

    fetchPc_d  = fetchPc_q;
    issuedPc_d = issuedPc_q;
    inflight_d = rom_req;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      fetchPc_d = redirect_pc;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      count_d   = '0;
    end else begin
      if (rom_req) begin
        fetchPc_d  = fetchPc_q + ADDR_WIDTH'(PC_STEP);
        issuedPc_d = fetchPc_q;
      end
      if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetchPc_q  <= RESET_PC;
      issuedPc_q <= '0;
      inflight_q <= 1'b0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        memData_q[i] <= '0;
        memPc_q[i]   <= '0;
      end
    end else begin
      fetchPc_q  <= fetchPc_d;
      issuedPc_q <= issuedPc_d;
      inflight_q <= inflight_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      if (push) begin
        memData_q[wrPtr_q] <= rom_data;
        memPc_q[wrPtr_q]   <= issuedPc_q;
      end
    end
  end

endmodule
